pipelined_segment_adder: RTL and testbench

//  Parametrised, pipelined unsigned adder; generalises the fixed 8-bit wrap adder to WIDTH bits.

---
 rtl/pipelined_segment_adder.sv | 91 +++++++++
 tb/tb_pipelined_segment_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_segment_adder.sv
// Pipelined unsigned adder: the carry ripples through WIDTH/SEG_W registered segments, one per stage.
// Define ADDER_SAT_EN to saturate the sum on overflow; by default the sum wraps mod 2^WIDTH.
module pipelined_segment_adder #(
  parameter int WIDTH = 8,
  parameter int SEG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int STAGES = WIDTH / SEG_W;

`ifdef ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  if (WIDTH < 2 || SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_param_err
    $error("pipelined_segment_adder: WIDTH must be >= 2 and a multiple of SEG_W");
  end

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] op_a, op_b, psum, nsum;
    logic             pcin, pvalid;
    logic [SEG_W:0]   seg;
    logic [WIDTH-1:0] ra, rb, rs;
    logic             rc, rv;
    logic             unused_ops;

    if (k == 0) begin : g_head
      assign op_a   = a;
      assign op_b   = b;
      assign psum   = '0;
      assign pcin   = 1'b0;
      assign pvalid = in_valid;
    end else begin : g_link
      assign op_a   = g_stage[k-1].ra;
      assign op_b   = g_stage[k-1].rb;
      assign psum   = g_stage[k-1].rs;
      assign pcin   = g_stage[k-1].rc;
      assign pvalid = g_stage[k-1].rv;
    end

    assign seg = {1'b0, op_a[k*SEG_W +: SEG_W]} + {1'b0, op_b[k*SEG_W +: SEG_W]}
               + {{SEG_W{1'b0}}, pcin};

    // Saturation only touches the final stage so latency is the same in both builds.
    always_comb begin
      nsum = psum;
      nsum[k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
      if (SAT && (k == STAGES-1) && seg[SEG_W]) nsum = '1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rv <= 1'b0;
        rc <= 1'b0;
        rs <= '0;
        ra <= '0;
        rb <= '0;
      end else if (advance) begin
        rv <= pvalid;
        rc <= seg[SEG_W];
        rs <= nsum;
        ra <= op_a;
        rb <= op_b;
      end
    end

    // Already-consumed operand bits are dead; synthesis trims them.
    assign unused_ops = ^{ra, rb};
  end

  assign out_valid = g_stage[STAGES-1].rv;
  assign sum       = g_stage[STAGES-1].rs;
  assign carry_out = g_stage[STAGES-1].rc;

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Scoreboard bench for pipelined_segment_adder (WIDTH=8, SEG_W=2): directed vectors,
// latency, bubbles, back-pressure hold, and reset flush of a full pipeline.
module tb_pipelined_segment_adder;
  localparam int WIDTH  = 8;
  localparam int SEG_W  = 2;
  localparam int STAGES = WIDTH / SEG_W;
  localparam int NVEC   = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       in_ready, out_valid, carry_out;
  logic [7:0] sum;

  pipelined_segment_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_pop = -1;
  bit   gap_mode = 1'b0;
  int   ready_mode = 0;  // 0: always ready, 1: never ready, 2: fixed stall pattern

  // {a, b, wrapped sum, carry}, worked out by hand
  logic [24:0] vecs [NVEC] = '{
    {8'h00, 8'h00, 8'h00, 1'b0},
    {8'hFF, 8'h01, 8'h00, 1'b1},
    {8'hFF, 8'hFF, 8'hFE, 1'b1},
    {8'h01, 8'h01, 8'h02, 1'b0},
    {8'h55, 8'hAA, 8'hFF, 1'b0},
    {8'h80, 8'h80, 8'h00, 1'b1},
    {8'h7F, 8'h01, 8'h80, 1'b0},
    {8'h0F, 8'hF1, 8'h00, 1'b1},
    {8'h3C, 8'hC3, 8'hFF, 1'b0},
    {8'h12, 8'h34, 8'h46, 1'b0},
    {8'hC8, 8'h64, 8'h2C, 1'b1},
    {8'hAB, 8'hCD, 8'h78, 1'b1},
    {8'h03, 8'h01, 8'h04, 1'b0},
    {8'h3F, 8'h01, 8'h40, 1'b0}
  };

  function automatic exp_t mk(input logic [7:0] s_wrap, input logic c);
    exp_t e;
`ifdef ADDER_SAT_EN
    e.s = c ? 8'hFF : s_wrap;
`else
    e.s = s_wrap;
`endif
    e.c = c;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  logic [15:0] pat = 16'b1011_0010_1100_1001;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: begin
        out_ready = pat[0];
        pat = {pat[0], pat[15:1]};
      end
    endcase
  end

  // Monitor: pops and compares on every output handshake, checks hold while stalled.
  logic       stall_prev = 1'b0;
  logic [7:0] held_s;
  logic       held_c;
  always @(negedge clk) begin
    exp_t e;
    check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (stall_prev) begin
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_sum", {23'd0, carry_out, sum}, {23'd0, held_c, held_s});
    end
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got sum=%0h carry=%0b, expected no beat", sum, carry_out);
      end else begin
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("carry", 32'(carry_out), 32'(e.c));
      end
      if (gap_mode && last_pop >= 0) check("gap", 32'(cyc - last_pop), 32'(2));
      last_pop = cyc;
    end
    stall_prev = !rst && out_valid && !out_ready;
    held_s = sum;
    held_c = carry_out;
  end

  task automatic send(input int idx);
    int n = 0;
    a = vecs[idx][24:17];
    b = vecs[idx][16:9];
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 for vector %0d", idx);
    end else begin
      q.push_back(mk(vecs[idx][8:1], vecs[idx][0]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    ready_mode = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_carry", 32'(carry_out), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;

    // single beat latency: accept at edge t -> out_valid after edge t+STAGES-1
    send(1);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("latency", 32'(n), 32'(STAGES - 1));
    drain();

    for (int i = 0; i < NVEC; i++) send(i);
    drain();

    last_pop = -1;
    gap_mode = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      send(i);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    drain();
    gap_mode = 1'b0;

    ready_mode = 2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NVEC; i++) send(i);
    drain();

    // fill with downstream stalled, then reset must flush everything
    ready_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 4; i < 8; i++) send(i);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'(1));
    check("full_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'(0));
    check("flush_sum", 32'(sum), 32'(0));
    check("flush_carry", 32'(carry_out), 32'(0));
    check("flush_in_ready", 32'(in_ready), 32'(1));
    ready_mode = 0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
